sram_axi_arbiter: RTL and testbench
===================================

Name: sram_axi_arbiter

Overview:
- Shares the bridge's single read engine (AR/R) and single write engine (AW/W/B) between the instruction and data SRAM-like ports of the CPU.
- Accepted reads are tagged in a small in-order FIFO so each read data_ok is routed back to its originating port.
- Data-port ordering is preserved: a data write and data reads are never outstanding together.
- Sits between the CPU SRAM-like interfaces and the read/write channel engines.

Parameters:
- RD_DEPTH, 4, max outstanding reads (tag FIFO depth, power of 2, >=2)
- RD_PTR_W, 2, log2(RD_DEPTH)

Ports:
- clk  in  1  clock, all state on posedge
- reset  in  1  asynchronous, active-high
- inst_sram_req  in  1  inst read request (inst port is read-only)
- inst_sram_size  in  2  transfer size
- inst_sram_addr  in  32  address
- inst_sram_addr_ok  out  1  inst request accepted this cycle
- inst_sram_data_ok  out  1  inst read data valid
- inst_sram_rdata  out  32  read data
- data_sram_req  in  1  data request
- data_sram_wr  in  1  1 = write
- data_sram_size  in  2  size
- data_sram_wstrb  in  4  byte strobes
- data_sram_addr  in  32  address
- data_sram_wdata  in  32  write data
- data_sram_addr_ok  out  1  data request accepted
- data_sram_data_ok  out  1  read data valid or write complete
- data_sram_rdata  out  32  read data
- rd_req  out  1  to read engine
- rd_size  out  2  selected size
- rd_addr  out  32  selected address
- rd_addr_ok  in  1  read engine accepted
- rd_data_ok  in  1  read engine returning data (in order)
- rd_rdata  in  32  returned data
- wr_req  out  1  to write engine
- wr_size  out  2
- wr_wstrb  out  4
- wr_addr  out  32
- wr_wdata  out  32
- wr_addr_ok  in  1  write engine accepted
- wr_data_ok  in  1  write response (B) complete

Behaviour:
- Reset (async): tag FIFO empty (rd/wr ptrs 0, count 0), data_rd_cnt=0, wr_pending=0. All *_addr_ok, *_data_ok, rd_req and wr_req are 0 while reset is high.
- State: tag FIFO of 1-bit source (0=inst, 1=data); data_rd_cnt (0..RD_DEPTH); wr_pending flag.
- Eligibility:
  - data read: data_sram_req & ~data_sram_wr & ~wr_pending & ~fifo_full.
  - data write: data_sram_req & data_sram_wr & ~wr_pending & data_rd_cnt==0.
  - inst read: inst_sram_req & ~fifo_full.
- Read arbitration (combinational, fixed priority, data > inst):
  - rd_req = data-read eligible | inst eligible.
  - rd_size/rd_addr are muxed from the winner.
- Write path: wr_req = data write eligible; wr_* fields pass straight through from the data port.
- addr_ok is combinational from the engine handshake:
  - data_sram_addr_ok = (data read won & rd_addr_ok) | (data write eligible & wr_addr_ok).
  - inst_sram_addr_ok = inst won & rd_addr_ok.
  - The loser sees addr_ok=0 and must hold its request.
- On read accept (rd_req & rd_addr_ok): push the source bit. If source=data, data_rd_cnt increments.
- On rd_data_ok with FIFO non-empty:
  - pop the head; raise the matching *_data_ok for that same cycle (combinational).
  - rdata = rd_rdata is broadcast to both ports.
  - If head=data, data_rd_cnt decrements.
- rd_data_ok with FIFO empty (stale after reset): ignored, no data_ok on either port.
- Simultaneous push and pop: both take effect, count unchanged. A push is never attempted while full, even if a pop happens the same cycle (fifo_full is evaluated from registered count).
- Write accept (wr_req & wr_addr_ok): wr_pending <= 1. On wr_data_ok: data_sram_data_ok=1 that cycle and wr_pending <= 0. The next data request becomes eligible the following cycle.
- wr_data_ok while wr_pending=0: ignored.
- Pointers wrap modulo RD_DEPTH.
- Ordering guarantees:
  - Read data_ok returns in acceptance order.
  - The data port never has a read and a write outstanding together, so no RAW hazard or reordering is possible.
- Latency: arbitration adds 0 cycles; all pushes, pops and flag updates are registered at the next posedge.

Test Plan:
- Inst read 0xBFC00000 alone, read engine addr_ok same cycle, data 0x3C1DA000 three cycles later -> inst_sram_addr_ok=1 in cycle 0; inst_sram_data_ok=1 with rdata=0x3C1DA000; data_sram_data_ok stays 0.
- Inst and data reads requested in the same cycle -> data wins (rd_addr=data addr, inst_sram_addr_ok=0). Inst is granted next cycle. Responses D then I route to data then inst.
- Four inst reads accepted with no response -> fifo_full; a fifth inst request gets rd_req=0. After one rd_data_ok, the fifth is accepted the next cycle.
- Data write 0x1FAF0000 wdata 0xDEADBEEF wstrb 0xF, then a data read to the same address -> read is held (rd_req=0 for data) until the cycle after wr_data_ok. The write's data_sram_data_ok precedes the read's.
- Two data reads outstanding, then a data write is requested -> wr_req=0 until both read data_oks return (data_rd_cnt=0), then the write is accepted.
- Reset asserted mid-flight with 3 reads outstanding, then a stale rd_data_ok after release -> no data_ok on either port; FIFO count=0.

Source files
------------

// File: rtl/sram_axi_arbiter.sv
// Arbitrates the CPU instruction and data SRAM-like ports onto one read engine and one write engine.
// A small in-order tag FIFO routes each read response back to the port that issued it.
module sram_axi_arbiter #(
  parameter int RD_DEPTH = 4,
  parameter int RD_PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        rd_req,
  output logic [1:0]  rd_size,
  output logic [31:0] rd_addr,
  input  logic        rd_addr_ok,
  input  logic        rd_data_ok,
  input  logic [31:0] rd_rdata,
  output logic        wr_req,
  output logic [1:0]  wr_size,
  output logic [3:0]  wr_wstrb,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_wdata,
  input  logic        wr_addr_ok,
  input  logic        wr_data_ok
);

  logic [RD_DEPTH-1:0] r_tag;
  logic [RD_PTR_W-1:0] r_wptr;
  logic [RD_PTR_W-1:0] r_rptr;
  logic [RD_PTR_W:0]   r_count;
  logic [RD_PTR_W:0]   r_data_rd_cnt;
  logic                r_wr_pending;

  logic w_run;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_data_rd_elig;
  logic w_data_wr_elig;
  logic w_inst_elig;
  logic w_inst_win;
  logic w_push;
  logic w_pop;
  logic w_head;
  logic w_push_data;
  logic w_pop_data;
  logic w_wr_done;

  // Count never exceeds RD_DEPTH (a power of two), so its MSB alone marks full.
  assign w_run        = ~reset;
  assign w_fifo_full  = r_count[RD_PTR_W];
  assign w_fifo_empty = (r_count == {(RD_PTR_W+1){1'b0}});

  assign w_data_rd_elig = w_run & data_sram_req & ~data_sram_wr & ~r_wr_pending & ~w_fifo_full;
  assign w_data_wr_elig = w_run & data_sram_req & data_sram_wr & ~r_wr_pending &
                          (r_data_rd_cnt == {(RD_PTR_W+1){1'b0}});
  assign w_inst_elig    = w_run & inst_sram_req & ~w_fifo_full;
  assign w_inst_win     = w_inst_elig & ~w_data_rd_elig;

  assign rd_req = w_data_rd_elig | w_inst_elig;

  // Data port has fixed priority over the instruction port on the read engine.
  always_comb begin
    rd_size = inst_sram_size;
    rd_addr = inst_sram_addr;
    if (w_data_rd_elig) begin
      rd_size = data_sram_size;
      rd_addr = data_sram_addr;
    end else begin
      rd_size = inst_sram_size;
      rd_addr = inst_sram_addr;
    end
  end

  assign wr_req   = w_data_wr_elig;
  assign wr_size  = data_sram_size;
  assign wr_wstrb = data_sram_wstrb;
  assign wr_addr  = data_sram_addr;
  assign wr_wdata = data_sram_wdata;

  assign w_push      = rd_req & rd_addr_ok;
  assign w_pop       = w_run & rd_data_ok & ~w_fifo_empty;
  assign w_head      = r_tag[r_rptr];
  assign w_push_data = w_push & w_data_rd_elig;
  assign w_pop_data  = w_pop & w_head;
  assign w_wr_done   = w_run & wr_data_ok & r_wr_pending;

  assign data_sram_addr_ok = (w_data_rd_elig & rd_addr_ok) | (w_data_wr_elig & wr_addr_ok);
  assign inst_sram_addr_ok = w_inst_win & rd_addr_ok;
  assign inst_sram_data_ok = w_pop & ~w_head;
  assign data_sram_data_ok = w_pop_data | w_wr_done;
  assign inst_sram_rdata   = rd_rdata;
  assign data_sram_rdata   = rd_rdata;

  // Tag FIFO storage and pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag  <= {RD_DEPTH{1'b0}};
      r_wptr <= {RD_PTR_W{1'b0}};
      r_rptr <= {RD_PTR_W{1'b0}};
    end else begin
      if (w_push) begin
        r_tag[r_wptr] <= w_data_rd_elig;
        r_wptr        <= r_wptr + {{(RD_PTR_W-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        r_rptr <= r_rptr + {{(RD_PTR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Occupancy of the tag FIFO; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= {(RD_PTR_W+1){1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + {{RD_PTR_W{1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{RD_PTR_W{1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Outstanding data-port reads; a data write waits until this drains to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_rd_cnt <= {(RD_PTR_W+1){1'b0}};
    end else begin
      case ({w_push_data, w_pop_data})
        2'b10:   r_data_rd_cnt <= r_data_rd_cnt + {{RD_PTR_W{1'b0}}, 1'b1};
        2'b01:   r_data_rd_cnt <= r_data_rd_cnt - {{RD_PTR_W{1'b0}}, 1'b1};
        default: r_data_rd_cnt <= r_data_rd_cnt;
      endcase
    end
  end

  // Single outstanding write; acceptance requires no pending write, so set and clear never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_pending <= 1'b0;
    end else if (wr_req & wr_addr_ok) begin
      r_wr_pending <= 1'b1;
    end else if (w_wr_done) begin
      r_wr_pending <= 1'b0;
    end else begin
      r_wr_pending <= r_wr_pending;
    end
  end

endmodule

// File: tb/tb_sram_axi_arbiter.sv
// Directed self-checking bench for sram_axi_arbiter; inputs change after the falling edge, outputs checked 1ns later.
module tb_sram_axi_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_sram_req;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        rd_req;
  logic [1:0]  rd_size;
  logic [31:0] rd_addr;
  logic        rd_addr_ok;
  logic        rd_data_ok;
  logic [31:0] rd_rdata;
  logic        wr_req;
  logic [1:0]  wr_size;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_addr;
  logic [31:0] wr_wdata;
  logic        wr_addr_ok;
  logic        wr_data_ok;

  int total_cnt;
  int bad_cnt;

  sram_axi_arbiter #(.RD_DEPTH(4), .RD_PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .rd_req(rd_req), .rd_size(rd_size), .rd_addr(rd_addr), .rd_addr_ok(rd_addr_ok),
    .rd_data_ok(rd_data_ok), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_size(wr_size), .wr_wstrb(wr_wstrb), .wr_addr(wr_addr),
    .wr_wdata(wr_wdata), .wr_addr_ok(wr_addr_ok), .wr_data_ok(wr_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    inst_sram_req   = 1'b0;
    inst_sram_size  = 2'd2;
    inst_sram_addr  = 32'h0;
    data_sram_req   = 1'b0;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd2;
    data_sram_wstrb = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    rd_addr_ok      = 1'b0;
    rd_data_ok      = 1'b0;
    rd_rdata        = 32'h0;
    wr_addr_ok      = 1'b0;
    wr_data_ok      = 1'b0;
  endtask

  // Advance one posedge and land mid-low-phase, then restore idle inputs.
  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    idle();
    reset = 1'b1;

    // Reset: everything quiet even with requests and handshakes asserted.
    cyc();
    inst_sram_req = 1'b1; data_sram_req = 1'b1; data_sram_wr = 1'b1;
    rd_addr_ok = 1'b1; rd_data_ok = 1'b1; wr_addr_ok = 1'b1; wr_data_ok = 1'b1;
    settle();
    chk_eq("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk_eq("rst_wr_req", {31'd0, wr_req}, 32'd0);
    chk_eq("rst_i_aok",  {31'd0, inst_sram_addr_ok}, 32'd0);
    chk_eq("rst_d_aok",  {31'd0, data_sram_addr_ok}, 32'd0);
    chk_eq("rst_i_dok",  {31'd0, inst_sram_data_ok}, 32'd0);
    chk_eq("rst_d_dok",  {31'd0, data_sram_data_ok}, 32'd0);
    cyc();
    reset = 1'b0;

    // Lone inst read, data three cycles later.
    cyc();
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00000; rd_addr_ok = 1'b1;
    settle();
    chk_eq("t1_rd_req", {31'd0, rd_req}, 32'd1);
    chk_eq("t1_rd_addr", rd_addr, 32'hBFC00000);
    chk_eq("t1_i_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    chk_eq("t1_d_aok", {31'd0, data_sram_addr_ok}, 32'd0);
    cyc();
    settle();
    chk_eq("t1_i_dok_c1", {31'd0, inst_sram_data_ok}, 32'd0);
    cyc();
    cyc();
    rd_data_ok = 1'b1; rd_rdata = 32'h3C1DA000;
    settle();
    chk_eq("t1_i_dok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk_eq("t1_i_rdata", inst_sram_rdata, 32'h3C1DA000);
    chk_eq("t1_d_dok", {31'd0, data_sram_data_ok}, 32'd0);

    // Simultaneous inst and data reads: data wins, inst follows, responses D then I.
    cyc();
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00004;
    data_sram_req = 1'b1; data_sram_addr = 32'h00001000; data_sram_size = 2'd1;
    rd_addr_ok = 1'b1;
    settle();
    chk_eq("t2_rd_addr", rd_addr, 32'h00001000);
    chk_eq("t2_rd_size", {30'd0, rd_size}, 32'd1);
    chk_eq("t2_d_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    chk_eq("t2_i_aok", {31'd0, inst_sram_addr_ok}, 32'd0);
    cyc();
    inst_sram_req = 1'b1; inst_sram_addr = 32'hBFC00004; rd_addr_ok = 1'b1;
    settle();
    chk_eq("t2_rd_addr2", rd_addr, 32'hBFC00004);
    chk_eq("t2_i_aok2", {31'd0, inst_sram_addr_ok}, 32'd1);
    cyc();
    rd_data_ok = 1'b1; rd_rdata = 32'h11111111;
    settle();
    chk_eq("t2_d_dok", {31'd0, data_sram_data_ok}, 32'd1);
    chk_eq("t2_d_rdata", data_sram_rdata, 32'h11111111);
    chk_eq("t2_i_dok0", {31'd0, inst_sram_data_ok}, 32'd0);
    cyc();
    rd_data_ok = 1'b1; rd_rdata = 32'h22222222;
    settle();
    chk_eq("t2_i_dok", {31'd0, inst_sram_data_ok}, 32'd1);
    chk_eq("t2_d_dok0", {31'd0, data_sram_data_ok}, 32'd0);

    // Fill the tag FIFO with four inst reads; the fifth waits for a pop.
    for (int i = 0; i < 4; i++) begin
      cyc();
      inst_sram_req = 1'b1; inst_sram_addr = 32'h00000100 + 32'(i); rd_addr_ok = 1'b1;
      settle();
      chk_eq("t3_fill_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    end
    cyc();
    inst_sram_req = 1'b1; rd_addr_ok = 1'b1;
    data_sram_req = 1'b1;
    settle();
    chk_eq("t3_full_rd_req", {31'd0, rd_req}, 32'd0);
    chk_eq("t3_full_i_aok", {31'd0, inst_sram_addr_ok}, 32'd0);
    cyc();
    inst_sram_req = 1'b1; rd_addr_ok = 1'b1; rd_data_ok = 1'b1; rd_rdata = 32'hA0A0A0A0;
    settle();
    chk_eq("t3_pop_rd_req", {31'd0, rd_req}, 32'd0);
    chk_eq("t3_pop_i_dok", {31'd0, inst_sram_data_ok}, 32'd1);
    cyc();
    inst_sram_req = 1'b1; rd_addr_ok = 1'b1;
    settle();
    chk_eq("t3_fifth_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      rd_data_ok = 1'b1;
      settle();
      chk_eq("t3_drain_i_dok", {31'd0, inst_sram_data_ok}, 32'd1);
    end
    cyc();
    rd_data_ok = 1'b1;
    settle();
    chk_eq("t3_empty_i_dok", {31'd0, inst_sram_data_ok}, 32'd0);

    // Data write, then a read of the same address held until after the write response.
    cyc();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1FAF0000;
    data_sram_wdata = 32'hDEADBEEF; data_sram_wstrb = 4'hF; wr_addr_ok = 1'b1;
    settle();
    chk_eq("t4_wr_req", {31'd0, wr_req}, 32'd1);
    chk_eq("t4_wr_addr", wr_addr, 32'h1FAF0000);
    chk_eq("t4_wr_wdata", wr_wdata, 32'hDEADBEEF);
    chk_eq("t4_wr_wstrb", {28'd0, wr_wstrb}, 32'hF);
    chk_eq("t4_d_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    cyc();
    data_sram_req = 1'b1; data_sram_addr = 32'h1FAF0000; rd_addr_ok = 1'b1;
    settle();
    chk_eq("t4_hold_rd_req", {31'd0, rd_req}, 32'd0);
    chk_eq("t4_hold_d_aok", {31'd0, data_sram_addr_ok}, 32'd0);
    cyc();
    data_sram_req = 1'b1; data_sram_addr = 32'h1FAF0000; rd_addr_ok = 1'b1; wr_data_ok = 1'b1;
    settle();
    chk_eq("t4_wdone_dok", {31'd0, data_sram_data_ok}, 32'd1);
    chk_eq("t4_wdone_rd_req", {31'd0, rd_req}, 32'd0);
    cyc();
    data_sram_req = 1'b1; data_sram_addr = 32'h1FAF0000; rd_addr_ok = 1'b1;
    settle();
    chk_eq("t4_rd_req", {31'd0, rd_req}, 32'd1);
    chk_eq("t4_rd_addr", rd_addr, 32'h1FAF0000);
    chk_eq("t4_rd_d_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    cyc();
    rd_data_ok = 1'b1; rd_rdata = 32'hDEADBEEF;
    settle();
    chk_eq("t4_rd_dok", {31'd0, data_sram_data_ok}, 32'd1);
    chk_eq("t4_rd_rdata", data_sram_rdata, 32'hDEADBEEF);
    chk_eq("t4_rd_i_dok", {31'd0, inst_sram_data_ok}, 32'd0);

    // Two data reads outstanding block a data write until both return.
    for (int i = 0; i < 2; i++) begin
      cyc();
      data_sram_req = 1'b1; data_sram_addr = 32'h00002000 + 32'(4 * i); rd_addr_ok = 1'b1;
      settle();
      chk_eq("t5_rd_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    end
    cyc();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; wr_addr_ok = 1'b1;
    settle();
    chk_eq("t5_blk_wr_req", {31'd0, wr_req}, 32'd0);
    chk_eq("t5_blk_d_aok", {31'd0, data_sram_addr_ok}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      data_sram_req = 1'b1; data_sram_wr = 1'b1; wr_addr_ok = 1'b1; rd_data_ok = 1'b1;
      settle();
      chk_eq("t5_drain_wr_req", {31'd0, wr_req}, 32'd0);
      chk_eq("t5_drain_d_dok", {31'd0, data_sram_data_ok}, 32'd1);
    end
    cyc();
    data_sram_req = 1'b1; data_sram_wr = 1'b1; wr_addr_ok = 1'b1;
    settle();
    chk_eq("t5_wr_req", {31'd0, wr_req}, 32'd1);
    chk_eq("t5_wr_d_aok", {31'd0, data_sram_addr_ok}, 32'd1);
    cyc();
    wr_data_ok = 1'b1;
    settle();
    chk_eq("t5_wdone_dok", {31'd0, data_sram_data_ok}, 32'd1);
    cyc();
    wr_data_ok = 1'b1;
    settle();
    chk_eq("t5_stale_wdok", {31'd0, data_sram_data_ok}, 32'd0);

    // Reset with three reads in flight, then a stale response after release.
    for (int i = 0; i < 3; i++) begin
      cyc();
      inst_sram_req = 1'b1; rd_addr_ok = 1'b1;
      settle();
      chk_eq("t6_fill_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    end
    cyc();
    reset = 1'b1; rd_data_ok = 1'b1;
    settle();
    chk_eq("t6_rst_i_dok", {31'd0, inst_sram_data_ok}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    rd_data_ok = 1'b1; rd_rdata = 32'h55AA55AA;
    settle();
    chk_eq("t6_stale_i_dok", {31'd0, inst_sram_data_ok}, 32'd0);
    chk_eq("t6_stale_d_dok", {31'd0, data_sram_data_ok}, 32'd0);
    // An empty FIFO accepts exactly four reads before blocking.
    for (int i = 0; i < 4; i++) begin
      cyc();
      inst_sram_req = 1'b1; rd_addr_ok = 1'b1;
      settle();
      chk_eq("t6_cnt_aok", {31'd0, inst_sram_addr_ok}, 32'd1);
    end
    cyc();
    inst_sram_req = 1'b1; rd_addr_ok = 1'b1;
    settle();
    chk_eq("t6_cnt_full", {31'd0, rd_req}, 32'd0);

    cyc();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
